// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by alu_pipe and alu_muldiv_iter.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SRA   = 4'h7,
    OP_SLT   = 4'h8,
    OP_SLTU  = 4'h9,
    OP_MUL   = 4'hA,
    OP_MULHU = 4'hB,
    OP_DIVU  = 4'hC,
    OP_REMU  = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  // Ops handled by the iterative mul/div unit
  function automatic logic is_multicycle(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 shift-add multiplier and restoring divider.
// WIDTH steps per operation; the first step runs on the start edge so the
// final result is registered one cycle before the parent's counter expires.
// hi/lo hold {product high, product low} for multiply and
// {remainder, quotient} for divide.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;

  alu_op_e          s_op;
  logic [WIDTH-1:0] s_hi, s_lo, s_b, n_hi, n_lo, diff;
  logic [WIDTH:0]   sum, rem_s;

  // One iteration step, fed from the inputs on start, else from the registers
  always_comb begin
    if (start) begin
      s_op = op;
      s_hi = '0;
      s_lo = a;
      s_b  = b;
    end else begin
      s_op = op_q;
      s_hi = hi_q;
      s_lo = lo_q;
      s_b  = b_q;
    end
    sum   = {1'b0, s_hi} + (s_lo[0] ? {1'b0, s_b} : '0);
    rem_s = {s_hi, s_lo[WIDTH-1]};
    // remainder stays below the divisor, so the difference fits in WIDTH bits
    diff  = rem_s[WIDTH-1:0] - s_b;
    if ((s_op == OP_MUL) || (s_op == OP_MULHU)) begin
      n_hi = sum[WIDTH:1];
      n_lo = {sum[0], s_lo[WIDTH-1:1]};
    end else if (rem_s >= {1'b0, s_b}) begin
      n_hi = diff;
      n_lo = {s_lo[WIDTH-2:0], 1'b1};
    end else begin
      n_hi = rem_s[WIDTH-1:0];
      n_lo = {s_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Sequencing: load on start, iterate while busy, pulse done after the last step
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    done_d = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op;
      b_d    = b;
      hi_d   = n_hi;
      lo_d   = n_lo;
    end else if (busy_q) begin
      hi_d  = n_hi;
      lo_d  = n_lo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SHW'(WIDTH - 2)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_ADD;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
    end
  end

  assign done   = done_q;
  assign result = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_q : hi_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake on both sides.
// Optional feature macro: ALU_MULDIV_EN enables the iterative MUL/MULHU/DIVU/REMU
// unit; without it, ops A-D decode as single-cycle ADD.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_res;
  alu_op_e          op_in;
  logic [SHW-1:0]   shamt;
  logic             accept, go_busy, busy_last, md_done;
  logic [WIDTH-1:0] md_result;

  assign op_in      = alu_op_e'(ALU_operation);
  assign shamt      = B[SHW-1:0];
  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign ALU_result = result_q;
  assign zero       = zero_q;

`ifdef ALU_MULDIV_EN
  logic [SHW-1:0] cnt_q, cnt_d;

  assign go_busy   = is_multicycle(op_in);
  assign busy_last = (cnt_q == SHW'(WIDTH - 1));

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && go_busy),
    .op     (op_in),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result)
  );

  // BUSY cycle counter; cleared on every acceptance, wraps to 0 on leaving BUSY
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign go_busy   = 1'b0;
  assign busy_last = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  // Single-cycle datapath; unlisted opcodes fall back to ADD
  always_comb begin
    alu_res = A + B;
    case (op_in)
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_res = A + B;
    endcase
  end

  // FSM next state and output register loads. Acceptance is handled after the
  // per-state case because it can fire from both IDLE and DONE (back-to-back).
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        if (busy_last) begin
          state_d = S_DONE;
          if (md_done) begin
            result_d = md_result;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      zero_d = (A == B);
      if (go_busy) begin
        state_d = S_BUSY;
      end else begin
        state_d  = S_DONE;
        result_d = alu_res;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized + directed stimulus against a behavioural ALU model,
// with a queue scoreboard checked by an independent output monitor.
module tb_alu_pipe;

  localparam int unsigned W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_result;
  logic         zero;

  alu_pipe #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .A             (A),
    .B             (B),
    .ALU_operation (ALU_operation),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ALU_result    (ALU_result),
    .zero          (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int unsigned  acc_cyc;
    int unsigned  lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          ordy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference behaviour computed straight from the opcode table
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned     sh;
    logic [W-1:0]    na;
    logic [2*W-1:0]  p;
    sh = b % W;
    na = ~a;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (!MULDIV && op >= 4'hA && op <= 4'hD) return a + b;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << sh;
      4'h6: return a >> sh;
      4'h7: return a[W-1] ? ~(na >> sh) : (a >> sh);
      4'h8: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'h9: return (a < b) ? 1 : 0;
      4'hA: return p[W-1:0];
      4'hB: return p[2*W-1:W];
      4'hC: return (b == 0) ? '1 : a / b;
      4'hD: return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic int unsigned ref_latency(input logic [3:0] op);
    if (MULDIV && op >= 4'hA && op <= 4'hD) return W;
    return 1;
  endfunction

  function automatic logic pick_ordy();
    if (ordy_mode == 0) return 1'b0;
    if (ordy_mode == 1) return 1'b1;
    return ($urandom_range(3) != 0);
  endfunction

  // Drive one cycle of inputs; push the expected response if accepted
  task automatic drive_cycle(input logic iv, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid      = iv;
    ALU_operation = op;
    A             = a;
    B             = b;
    out_ready     = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) begin
      e.res     = ref_alu(op, a, b);
      e.zero    = (a == b);
      e.acc_cyc = cyc;
      e.lat     = ref_latency(op);
      sb.push_back(e);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int unsigned tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      drive_cycle(1'b1, op, a, b, pick_ordy(), acc);
      tries++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: op 0x%0h not accepted within %0d cycles", op, tries);
    end
  endtask

  task automatic idle(input int unsigned n);
    logic acc;
    for (int unsigned i = 0; i < n; i++) begin
      drive_cycle(1'b0, 4'($urandom_range(15)), $urandom, $urandom, pick_ordy(), acc);
    end
  endtask

  task automatic drain();
    logic        acc;
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      drive_cycle(1'b0, 4'h0, $urandom, $urandom, 1'b1, acc);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Output monitor: compares every presented result against the queue head
  initial begin : monitor
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        sb.delete();
        seen = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out_valid: got out_valid=1, expected 0 (no pending op)");
        end else begin
          if (!seen) begin
            check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
            seen = 1'b1;
          end
          check("result", ALU_result, sb[0].res);
          check("zero", zero, sb[0].zero);
          if (!out_ready) begin
            check("in_ready_hold", in_ready, 0);
          end else begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : driver
    int unsigned  tries;
    logic         acc;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    int unsigned  r;

    rst_n         = 1'b0;
    in_valid      = 1'b0;
    A             = '0;
    B             = '0;
    ALU_operation = 4'h0;
    out_ready     = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", ALU_result, 0);
    check("rst_zero", zero, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Basic ops and stated corner cases
    ordy_mode = 1;
    issue(4'h0, 32'd5, 32'd7, tries);
    issue(4'h1, 32'h1234, 32'h1234, tries);
    issue(4'h7, 32'h8000_0000, 32'd4, tries);
    issue(4'h5, 32'h0000_0003, 32'd33, tries);
    issue(4'h8, 32'hFFFF_FFFF, 32'd1, tries);
    issue(4'h9, 32'hFFFF_FFFF, 32'd1, tries);
    drain();

    // Back-to-back: each accepted on its first cycle
    for (int unsigned i = 0; i < 4; i++) begin
      issue(4'h0, 32'(i * 100), 32'(i + 1), tries);
      check("b2b_accept_tries", tries, 1);
    end

    // Backpressure: result held, nothing accepted for 3 cycles
    ordy_mode = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 4'h0, 32'd1, 32'd2, 1'b0, acc);
      check("bp_no_accept", acc, 0);
    end
    ordy_mode = 1;
    issue(4'h0, 32'd1, 32'd2, tries);
    check("bp_release_tries", tries, 1);
    drain();

    // Ops A-D: multi-cycle with the unit, ADD without
    issue(4'hA, 32'hFFFF_FFFF, 32'd2, tries);
    issue(4'hB, 32'hFFFF_FFFF, 32'd2, tries);
    issue(4'hC, 32'd100, 32'd0, tries);
    issue(4'hD, 32'd100, 32'd0, tries);
    issue(4'hA, 32'd3, 32'd4, tries);
    drain();

    // Reset partway through a MUL
    ordy_mode = 1;
    issue(4'hA, 32'h1234_5678, 32'h9ABC_DEF0, tries);
    ordy_mode = 0;
    idle(9);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", ALU_result, 0);
    check("midrst_zero", zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    ordy_mode = 1;
    issue(4'h0, 32'h11, 32'h22, tries);
    drain();

    // Randomized traffic with random backpressure
    ordy_mode = 2;
    for (int unsigned i = 0; i < 800; i++) begin
      a = $urandom;
      r = $urandom_range(7);
      if (r == 0)      b = a;
      else if (r == 1) b = '0;
      else if (r == 2) b = W'($urandom_range(40));
      else             b = $urandom;
      op = 4'($urandom_range(15));
      drive_cycle(($urandom_range(9) < 7), op, a, b, pick_ordy(), acc);
    end
    ordy_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
